mix_col_seq: RTL
================

Name: mix_col_seq

Overview:
- Parametrised, handshaked successor of the single-cycle MixColumns stage.
- Applies forward (encrypt) or inverse (decrypt) MixColumns, selected per block, to a Rijndael state of NB 32-bit columns.
- Processes COLS_PER_CYCLE columns per clock, trading area for latency.
- Sits between ShiftRows and AddRoundKey in the round datapath, with valid/ready flow control on both sides.

Parameters:
- NB, 4, number of state columns; legal values 4, 6, 8 (Rijndael block sizes 128/192/256).
- COLS_PER_CYCLE, 4, columns transformed per clock; must divide NB. Any other value is an elaboration-time error.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data and in_inv are valid.
- in_ready  output  1  block can accept a state.
- in_data  input  [0:32*NB-1]  input state; byte k = in_data[8k+:8]; column c = bytes 4c..4c+3, row 0 first.
- in_inv  input  1  0 selects forward MixColumns, 1 selects InvMixColumns.
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  [0:32*NB-1]  transformed state, same byte ordering as in_data.

Behaviour:
- Reset (rst==0 at a rising edge): state=IDLE, beat counter=0, work register=0, inv flag=0.
  - Resulting outputs: out_valid=0, out_data=0, in_ready=1.
- Reset overrides everything, including an in-flight block; that block is discarded with no output.
- FSM states: IDLE, BUSY, DONE. Define NBEATS = NB/COLS_PER_CYCLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational from state and out_ready only, never from in_valid.
- Accept occurs when in_valid && in_ready at an edge:
  - in_data is captured into the work register and in_inv into the inv flag.
  - Beat counter set to 0; state goes to BUSY.
- BUSY, each edge:
  - Columns beat*CPC .. beat*CPC+CPC-1 of the work register are replaced by their transform; other columns are unchanged.
  - Beat counter increments.
  - On the last beat (beat==NBEATS-1), state goes to DONE and the counter returns to 0.
- Latency: out_valid rises NBEATS edges after the accept edge (1 for defaults; 4 when CPC=1, NB=4).
- DONE:
  - out_valid=1 and out_data=work register, held stable while out_ready=0.
  - On out_valid && out_ready, if a new accept occurs in the same cycle, go to BUSY (back-to-back). Otherwise go to IDLE.
- Throughput: one block per NBEATS+1 cycles with back-to-back accept. Accept is ignored in BUSY because in_ready=0 there.
- out_data is the work register directly: it shows partially transformed values in BUSY and is only meaningful when out_valid=1.
- Forward matrix rows: [02 03 01 01], [01 02 03 01], [01 01 02 03], [03 01 01 02].
- Inverse matrix rows: [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e].
- Arithmetic is GF(2^8) with reduction polynomial 0x11b.
  - xtime(a) = {a[1:7],0} ^ (a[0] ? 8'h1b : 0), where a[0] is the MSB.
  - Higher coefficients are built from xtime chains and XOR.
  - All intermediates are exactly 8 bits; no integer-width arithmetic.
- in_inv is sampled only at accept; changes while BUSY or DONE have no effect.

Decomposition:
- Package aes_gf_pkg holds:
  - xtime and gf_mul_const (coefficient set {01,02,03,09,0b,0d,0e}) functions;
  - the AES_POLY=8'h1b constant;
  - the FSM state typedef (IDLE/BUSY/DONE).
- Sub-module mix_single_column: combinational, 32-bit column in, inv in, 32-bit column out. Instantiated COLS_PER_CYCLE times.
- The beat counter selects which column slice feeds each instance; results are written back to the same slice.

Test Plan:
- Forward, NB=4, CPC=4:
  - Columns db135345, f20a225c, 01010101, c6c6c6c6 -> 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6.
  - out_valid 1 edge after accept.
- Inverse, same config: feed 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6 with in_inv=1 -> db135345, f20a225c, 01010101, c6c6c6c6.
- FIPS-197 round-1 column, CPC=1: d4bf5d30 (repeated in all 4 columns) -> 046681e5 in every column. out_valid exactly 4 edges after accept; in_ready=0 during BUSY.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out_data and out_valid stable, in_ready=0.
  - Then assert out_ready with in_valid=1 -> new block accepted in the same cycle; next result after NBEATS edges.
- Reset mid-operation, CPC=1: drive rst=0 on the 2nd BUSY edge -> next cycle out_valid=0, out_data=0, in_ready=1. No result is emitted for the aborted block.
- NB=8, CPC=2, random states: compare against a software reference for 1000 blocks, forward then inverse round-trip equals the input. Latency is 4 edges.

Source files
------------

// File: rtl/aes_gf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_gf_pkg                                                           |
// | GF(2^8) helpers and FSM state type for the MixColumns datapath.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package aes_gf_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    // Only the coefficients that appear in the forward and inverse matrices.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] res;
        x2  = xtime(a);
        x4  = xtime(x2);
        x8  = xtime(x4);
        res = 8'h00;
        case (c)
            8'h01:   res = a;
            8'h02:   res = x2;
            8'h03:   res = x2 ^ a;
            8'h09:   res = x8 ^ a;
            8'h0b:   res = x8 ^ x2 ^ a;
            8'h0d:   res = x8 ^ x4 ^ a;
            8'h0e:   res = x8 ^ x4 ^ x2;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mix_single_column.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mix_single_column                                                    |
// | Combinational forward/inverse MixColumns on one 32-bit column.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mix_single_column
    import aes_gf_pkg::*;
(
    input  logic [31:0] i_col,
    input  logic        i_inv,
    output logic [31:0] o_col
);

    logic [7:0] w_b   [4];
    logic [7:0] w_res [4];

    // Row 0 sits in the most significant byte of the column.
    assign w_b[0] = i_col[31:24];
    assign w_b[1] = i_col[23:16];
    assign w_b[2] = i_col[15:8];
    assign w_b[3] = i_col[7:0];

    for (genvar r = 0; r < 4; r++) begin : g_row
        assign w_res[r] = i_inv
            ? (gf_mul_const(w_b[r], 8'h0e)       ^ gf_mul_const(w_b[(r+1)%4], 8'h0b) ^
               gf_mul_const(w_b[(r+2)%4], 8'h0d) ^ gf_mul_const(w_b[(r+3)%4], 8'h09))
            : (gf_mul_const(w_b[r], 8'h02)       ^ gf_mul_const(w_b[(r+1)%4], 8'h03) ^
               w_b[(r+2)%4]                      ^ w_b[(r+3)%4]);
    end

    assign o_col = {w_res[0], w_res[1], w_res[2], w_res[3]};

endmodule
`default_nettype wire

// File: rtl/mix_col_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mix_col_seq                                                          |
// | Handshaked multi-beat (Inv)MixColumns over an NB-column state.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mix_col_seq
    import aes_gf_pkg::*;
#(
    parameter int NB             = 4,
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:32*NB-1]  in_data,
    input  logic              in_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:32*NB-1]  out_data
);

    if (!(NB == 4 || NB == 6 || NB == 8) || COLS_PER_CYCLE < 1 ||
        (NB % COLS_PER_CYCLE) != 0) begin : g_bad_param
        $error("mix_col_seq: illegal NB=%0d / COLS_PER_CYCLE=%0d", NB, COLS_PER_CYCLE);
    end

    localparam int NBEATS = NB / COLS_PER_CYCLE;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BEAT_W-1:0]   r_beat;
    logic [0:32*NB-1]    r_work;
    logic                r_inv;
    logic [0:32*NB-1]    w_work_nxt;
    logic                w_accept;
    logic                w_last;
    logic [31:0]         w_col_in  [COLS_PER_CYCLE];
    logic [31:0]         w_col_out [COLS_PER_CYCLE];

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_beat == BEAT_W'(NBEATS - 1));
    assign out_data = r_work;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = BUSY;
            end
            BUSY: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                // Result leaving and a new block arriving can share one edge.
                in_ready  = out_ready;
                if (out_ready) w_state_nxt = in_valid ? BUSY : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The beat counter steers one column slice into each lane.
    always_comb begin
        for (int l = 0; l < COLS_PER_CYCLE; l++) w_col_in[l] = '0;
        for (int b = 0; b < NBEATS; b++) begin
            if (r_beat == BEAT_W'(b)) begin
                for (int l = 0; l < COLS_PER_CYCLE; l++)
                    w_col_in[l] = r_work[32*(b*COLS_PER_CYCLE+l) +: 32];
            end
        end
    end

    for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
        mix_single_column u_col (
            .i_col (w_col_in[l]),
            .i_inv (r_inv),
            .o_col (w_col_out[l])
        );
    end

    always_comb begin
        w_work_nxt = r_work;
        for (int b = 0; b < NBEATS; b++) begin
            if (r_beat == BEAT_W'(b)) begin
                for (int l = 0; l < COLS_PER_CYCLE; l++)
                    w_work_nxt[32*(b*COLS_PER_CYCLE+l) +: 32] = w_col_out[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_work  <= '0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_work <= in_data;
                r_inv  <= in_inv;
                r_beat <= '0;
            end else if (r_state == BUSY) begin
                r_work <= w_work_nxt;
                r_beat <= w_last ? '0 : r_beat + BEAT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
